// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller:
// controller states and the load/store access size encoding (funct3).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

endpackage

// File: rtl/dmem_align.sv
// Lane steering for data-memory accesses (purely combinational):
// store byte-enables and lane replication, load byte/half extraction with
// sign/zero extension, and the misalignment flag. Unknown sizes act as word.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addrLo,
  input  logic [31:0] wData,
  input  logic [31:0] memRData,
  output logic [3:0]  memBe,
  output logic [31:0] memWData,
  output logic [31:0] loadData,
  output logic        misaligned
);

  logic [1:0]  width;        // 0 = byte, 1 = half, 2 = word
  logic        isUnsigned;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  assign laneByte = memRData[{addrLo, 3'b000} +: 8];
  assign laneHalf = memRData[{addrLo[1], 4'b0000} +: 16];

  // Decode funct3 into access width and signedness.
  always_comb begin
    width      = 2'd2;
    isUnsigned = 1'b0;
    case (size)
      MEM_B:   width = 2'd0;
      MEM_BU:  begin width = 2'd0; isUnsigned = 1'b1; end
      MEM_H:   width = 2'd1;
      MEM_HU:  begin width = 2'd1; isUnsigned = 1'b1; end
      default: width = 2'd2;
    endcase
  end

  // Build store lanes, extract the load lane and flag misalignment.
  always_comb begin
    memBe      = 4'b1111;
    memWData   = wData;
    loadData   = memRData;
    misaligned = 1'b0;
    case (width)
      2'd0: begin
        memBe    = 4'b0001 << addrLo;
        memWData = {4{wData[7:0]}};
        loadData = isUnsigned ? {24'd0, laneByte} : {{24{laneByte[7]}}, laneByte};
      end
      2'd1: begin
        memBe      = 4'b0011 << addrLo;
        memWData   = {2{wData[15:0]}};
        loadData   = isUnsigned ? {16'd0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
        misaligned = addrLo[0];
      end
      default: begin
        misaligned = |addrLo;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: accepts memRead/memWrite from the
// pipeline, runs a req/ack transaction with the data memory and stalls the
// pipeline until the access completes (IDLE -> REQ -> DONE).
// Optional macro DMEM_TIMEOUT_EN adds a REQ-cycle watchdog that abandons an
// access after TIMEOUT_CYCLES cycles without memAck.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              enable,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wData,
  output logic [31:0]       rData,
  output logic              stall,
  output logic              misaligned,
  output logic              timeout,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-3:0] memAddr,
  output logic [3:0]        memBe,
  output logic [31:0]       memWData,
  input  logic [31:0]       memRData,
  input  logic              memAck
);

  dmem_state_t state;
  logic [2:0]  sizeReg;
  logic [1:0]  addrLoReg;
  logic        take;
  logic        expire;
  logic [2:0]  alSize;
  logic [1:0]  alAddrLo;
  logic [3:0]  alBe;
  logic [31:0] alWData;
  logic [31:0] alLoad;
  logic        alMis;

  assign take = (state == IDLE) && enable && (memRead || memWrite);

  // Hold the pipeline in the request cycle and for the whole memory wait.
  assign stall = rstN && (take || (state == REQ));

  // In IDLE the align block looks at the incoming request; afterwards it
  // works on the captured size/offset so the load lane matches the request.
  assign alSize   = (state == IDLE) ? funct3    : sizeReg;
  assign alAddrLo = (state == IDLE) ? addr[1:0] : addrLoReg;

  dmem_align u_align (
    .size       (alSize),
    .addrLo     (alAddrLo),
    .wData      (wData),
    .memRData   (memRData),
    .memBe      (alBe),
    .memWData   (alWData),
    .loadData   (alLoad),
    .misaligned (alMis)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] waitCnt;

  // Count REQ cycles; the count restarts from zero on every entry to REQ.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)              waitCnt <= '0;
    else if (state == REQ)  waitCnt <= waitCnt + 1'b1;
    else                    waitCnt <= '0;
  end

  assign expire = (state == REQ) && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // Controller FSM, captured request and memory-side registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      sizeReg    <= 3'd0;
      addrLoReg  <= 2'd0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memBe      <= 4'd0;
      memWData   <= 32'd0;
      rData      <= 32'd0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          misaligned <= 1'b0;
          timeout    <= 1'b0;
          if (take) begin
            sizeReg   <= funct3;
            addrLoReg <= addr[1:0];
            memWe     <= memWrite;
            memAddr   <= addr[ADDR_W-1:2];
            memBe     <= alBe;
            memWData  <= alWData;
            if (alMis) begin
              state      <= DONE;
              misaligned <= 1'b1;
              rData      <= 32'd0;
            end else begin
              state  <= REQ;
              memReq <= 1'b1;
            end
          end
        end
        REQ: begin
          if (memAck) begin
            memReq <= 1'b0;
            state  <= DONE;
            if (!memWe) rData <= alLoad;
          end else if (expire) begin
            memReq  <= 1'b0;
            state   <= DONE;
            timeout <= 1'b1;
            rData   <= 32'd0;
          end
        end
        DONE: begin
          state      <= IDLE;
          misaligned <= 1'b0;
          timeout    <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios followed by random load/store
// traffic. A byte-level reference memory predicts load results; a word-wide
// responder memory stands in for the real data memory.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable, memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wData;
  logic [31:0] rData;
  logic        stall, misaligned, timeout, memReq, memWe;
  logic [29:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWData, memRData;
  logic        memAck;

  int checks = 0;
  int errors = 0;

  logic [7:0]  refMem [64];
  logic [31:0] wordMem [16];

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstN(rstN), .enable(enable), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .addr(addr), .wData(wData), .rData(rData), .stall(stall),
    .misaligned(misaligned), .timeout(timeout), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memBe(memBe), .memWData(memWData), .memRData(memRData),
    .memAck(memAck)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sizeBytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Expected load value assembled from the byte-level reference memory.
  function automatic logic [31:0] loadExp(input logic [2:0] f3, input logic [31:0] a);
    int n = sizeBytes(f3);
    logic [31:0] v = 32'd0;
    logic [5:0] off = a[5:0];
    for (int k = 0; k < n; k++) v[8*k +: 8] = refMem[6'(off + 6'(k))];
    if (n == 1 && f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (n == 2 && f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    wordMem[a[5:2]] = w;
    for (int k = 0; k < 4; k++) refMem[{a[5:2], 2'(k)}] = w[8*k +: 8];
  endtask

  // One complete access starting at an IDLE-cycle negedge; returns at the
  // DONE-cycle negedge with the request still presented.
  task automatic access(input bit wr, input bit rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int ackAt);
    int n = sizeBytes(f3);
    bit mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    logic [3:0]  expBe = (n == 1) ? (4'b0001 << a[1:0]) : (n == 2) ? (4'b0011 << a[1:0]) : 4'b1111;
    logic [31:0] expWd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
    @(negedge clk);
    enable = 1'b1; memRead = rd; memWrite = wr; funct3 = f3; addr = a; wData = wd;
    #1;
    check("stall_reqcycle", 32'(stall), 32'd1);
    check("memreq_reqcycle", 32'(memReq), 32'd0);
    if (!mis) begin
      for (int i = 1; i <= ackAt; i++) begin
        @(negedge clk);
        check("memreq_req", 32'(memReq), 32'd1);
        check("stall_req", 32'(stall), 32'd1);
        if (i == 1) begin
          check("memwe", 32'(memWe), 32'(wr));
          check("memaddr", 32'(memAddr), {2'b00, a[31:2]});
          check("membe", 32'(memBe), 32'(expBe));
          check("memwdata", memWData, expWd);
        end
        enable = 1'($urandom_range(0, 1));
        if (i == ackAt) begin
          memAck = 1'b1;
          memRData = wordMem[a[5:2]];
          if (memWe)
            for (int b = 0; b < 4; b++)
              if (memBe[b]) wordMem[a[5:2]][8*b +: 8] = memWData[8*b +: 8];
        end
      end
    end
    @(negedge clk);
    memAck = 1'b0;
    check("stall_done", 32'(stall), 32'd0);
    check("memreq_done", 32'(memReq), 32'd0);
    check("misaligned_done", 32'(misaligned), 32'(mis));
    check("timeout_done", 32'(timeout), 32'd0);
    if (mis) check("rdata_mis", rData, 32'd0);
    else if (!wr) check("rdata_load", rData, loadExp(f3, a));
    if (wr && !mis)
      for (int k = 0; k < n; k++) refMem[6'(a[5:0] + 6'(k))] = wd[8*k +: 8];
  endtask

  // One cycle with no request; optionally a stray memAck that must be ignored.
  task automatic idle(input bit strayAck);
    logic [31:0] prevR;
    @(negedge clk);
    prevR = rData;
    memRead = 1'b0; memWrite = 1'b0; enable = 1'($urandom_range(0, 1));
    memAck = strayAck; memRData = 32'hFFFF_FFFF;
    #1;
    check("stall_idle", 32'(stall), 32'd0);
    @(negedge clk);
    memAck = 1'b0;
    check("memreq_idle", 32'(memReq), 32'd0);
    check("stall_idle2", 32'(stall), 32'd0);
    check("rdata_idle", rData, prevR);
  endtask

  initial begin
    rstN = 1'b0; enable = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wData = 32'd0; memRData = 32'd0; memAck = 1'b0;
    for (int k = 0; k < 16; k++) preload(32'(k * 4), $urandom);

    // Reset state
    #12;
    check("rst_memreq", 32'(memReq), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_membe", 32'(memBe), 32'd0);
    check("rst_memaddr", 32'(memAddr), 32'd0);
    check("rst_memwdata", memWData, 32'd0);
    check("rst_rdata", rData, 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk); rstN = 1'b1;

    // LW 0x100, ack in the 3rd REQ cycle
    preload(32'h100, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 3'b010, 32'h100, 32'd0, 3);
    check("lw_const", rData, 32'hDEAD_BEEF);
    idle(1'b0);

    // LB / LBU at 0x103
    preload(32'h100, 32'h80FF_0000);
    access(1'b0, 1'b1, 3'b000, 32'h103, 32'd0, 2);
    check("lb_const", rData, 32'hFFFF_FF80);
    access(1'b0, 1'b1, 3'b100, 32'h103, 32'd0, 1);
    check("lbu_const", rData, 32'h0000_0080);
    idle(1'b0);

    // SH then LH at 0x102
    preload(32'h100, 32'h0000_0000);
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'h1234_ABCD, 2);
    access(1'b0, 1'b1, 3'b001, 32'h102, 32'd0, 1);
    check("lh_const", rData, 32'hFFFF_ABCD);
    idle(1'b0);

    // Misaligned LW at 0x101: no memory access
    access(1'b0, 1'b1, 3'b010, 32'h101, 32'd0, 1);
    check("mis_const", rData, 32'd0);
    idle(1'b0);

    // Back-to-back SW and LW, stray ack in IDLE afterwards
    access(1'b1, 1'b0, 3'b010, 32'h140, 32'hCAFE_F00D, 1);
    access(1'b0, 1'b1, 3'b010, 32'h140, 32'd0, 1);
    check("b2b_const", rData, 32'hCAFE_F00D);
    idle(1'b1);

    // Reset during the 2nd REQ cycle
    @(negedge clk);
    enable = 1'b1; memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; addr = 32'h108;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_memreq", 32'(memReq), 32'd1);
    rstN = 1'b0;
    #1;
    check("midrst_memreq", 32'(memReq), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    memRead = 1'b0;
    rstN = 1'b1;
    idle(1'b0);

    // Watchdog behaviour
    preload(32'h10C, 32'h1357_9BDF);
    access(1'b0, 1'b1, 3'b010, 32'h10C, 32'd0, 1);
`ifdef DMEM_TIMEOUT_EN
    @(negedge clk);
    enable = 1'b1; memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010; addr = 32'h110;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("to_memreq", 32'(memReq), 32'd1);
    end
    @(negedge clk);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_rdata", rData, 32'd0);
    check("to_memreq_done", 32'(memReq), 32'd0);
    check("to_stall_done", 32'(stall), 32'd0);
    idle(1'b0);
    check("to_cleared", 32'(timeout), 32'd0);
`else
    access(1'b0, 1'b1, 3'b010, 32'h110, 32'd0, 20);
    idle(1'b0);
`endif

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      int sel = $urandom_range(0, 2);
      bit wr = (sel != 0);
      bit rd = (sel != 1);
      logic [2:0] f3;
      if (wr) begin
        logic [2:0] sf [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
        f3 = sf[$urandom_range(0, 4)];
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      access(wr, rd, f3, 32'h2000 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
    end
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
